pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, 1, total cycles IF/ID is flushed per taken branch (range 1-7).
REQ-002 Parameter: LOAD_STALL_CYCLES, 1, total stall cycles per load-use hazard (range 1-7).
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high.
REQ-005 Port: IF_ID__instruction  in  32  instruction held in IF/ID; rs1=[19:15], rs2=[24:20].
REQ-006 Port: ID_EX_MemRead  in  1  instruction in ID/EX is a load.
REQ-007 Port: ID_EX_rd  in  5  destination register of ID/EX instruction.
REQ-008 Port: branch_taken  in  1  EX resolved a taken branch/jump this cycle.
REQ-009 Port: imem_busy  in  1  instruction memory cannot return a fetch this cycle.
REQ-010 Port: PC_Write  out  1  PC register load enable.
REQ-011 Port: IF_ID_Write  out  1  IF/ID load enable.
REQ-012 Port: IF_ID_Flush  out  1  IF/ID loads zero (bubble).
REQ-013 Port: ID_EX_Bubble  out  1  ID/EX control fields forced to zero.
REQ-014 Port: ctrl_state  out  2  current state encoding (RUN=0, STALL=1, FLUSH=2, WAIT=3).
REQ-015 Port: stall_cycles  out  32  perf counter (see Configuration).
REQ-016 Port: flush_events  out  32  perf counter (see Configuration).

Function
REQ-017 load_use SHALL be ID_EX_MemRead && ID_EX_rd!=0 && (ID_EX_rd==rs1 || ID_EX_rd==rs2).
REQ-018 Outputs SHALL be Mealy: combinational from state, remaining-count register and inputs; state/count update on rising clk.
REQ-019 Priority in every state SHALL be branch_taken > load_use > imem_busy.
REQ-020 Normal outputs: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0.
REQ-021 Redirect outputs (branch_taken=1, any state): PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1; next state FLUSH with count=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
REQ-022 Stall outputs (load_use=1 in RUN or WAIT, no branch): PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Bubble=1; next STALL with count=LOAD_STALL_CYCLES-1 if >1, else RUN.
REQ-023 Wait outputs (imem_busy=1 in RUN, no branch/load_use): PC_Write=0, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=0; next WAIT.
REQ-024 STALL: stall outputs held, count decrements each cycle; at count==1 next RUN; branch_taken aborts per REQ-021.
REQ-025 FLUSH: IF_ID_Flush=1, ID_EX_Bubble=0, PC_Write=!imem_busy, IF_ID_Write=1; count decrements; at count==1 next RUN (WAIT if imem_busy); branch_taken restarts FLUSH count.
REQ-026 WAIT: wait outputs while imem_busy=1; imem_busy=0 with no other event -> normal outputs, next RUN.
REQ-027 No output combination SHALL assert IF_ID_Write=0 and IF_ID_Flush=1 together.

Reset
REQ-028 reset=1 SHALL, at the next edge, set state RUN, count 0, counters 0.
REQ-029 While reset=1, outputs SHALL be PC_Write=0, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1, ctrl_state=0, regardless of inputs; reset mid-STALL/FLUSH/WAIT abandons the sequence.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN defined: stall_cycles increments each non-reset cycle with PC_Write=0; flush_events increments each non-reset cycle with branch_taken=1; both wrap 0xFFFFFFFF->0.
REQ-031 Macro undefined: stall_cycles and flush_events SHALL be constant 0 and no counter flops synthesized; all other behaviour identical.

Verification
REQ-032 Load-use: ID_EX_MemRead=1, ID_EX_rd=5, instr rs1=5, LOAD_STALL_CYCLES=1 -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, state stays RUN.
REQ-033 x0 exclusion: ID_EX_rd=0, rs1=0, MemRead=1 -> normal outputs, no stall.
REQ-034 FLUSH_CYCLES=2, branch_taken pulse -> cycle0 redirect outputs, cycle1 state FLUSH with IF_ID_Flush=1, cycle2 RUN; flush_events=1 with macro.
REQ-035 Branch during STALL (LOAD_STALL_CYCLES=3, branch at stall cycle 2) -> redirect outputs that cycle, stall abandoned.
REQ-036 imem_busy high 3 cycles -> 3 cycles PC_Write=0, IF_ID_Flush=1, state WAIT; then RUN; stall_cycles=3 with macro, 0 without.
REQ-037 reset asserted mid-FLUSH -> REQ-029 outputs immediately, state RUN and counters 0 after edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and fetch-wait sequencing with Mealy outputs.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_ID__instruction,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_rd,
  input  logic        branch_taken,
  input  logic        imem_busy,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    WAIT  = 2'd3
  } state_e;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic [4:0] rs1, rs2;
  logic       load_use;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble;
  logic       unused_instr_bits;

  assign rs1      = IF_ID__instruction[19:15];
  assign rs2      = IF_ID__instruction[24:20];
  assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                    ((ID_EX_rd == rs1) || (ID_EX_rd == rs2));
  assign unused_instr_bits = ^{IF_ID__instruction[31:25], IF_ID__instruction[14:0]};

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = RUN;
    cnt_d       = 3'd0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (branch_taken) begin
      // A redirect always wins and (re)starts the flush window.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_INIT;
      end
    end else begin
      unique case (state_q)
        STALL: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (cnt_q > 3'd1) begin
            state_d = STALL;
            cnt_d   = cnt_q - 3'd1;
          end
        end
        FLUSH: begin
          pc_write   = !imem_busy;
          ifid_flush = 1'b1;
          if (cnt_q > 3'd1) begin
            state_d = FLUSH;
            cnt_d   = cnt_q - 3'd1;
          end else if (imem_busy) begin
            state_d = WAIT;
          end
        end
        default: begin
          // RUN and WAIT share the same event handling.
          if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = STALL;
              cnt_d   = STALL_INIT;
            end
          end else if (imem_busy) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            state_d    = WAIT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC_Write     = pc_write;
  assign IF_ID_Write  = ifid_write;
  assign IF_ID_Flush  = ifid_flush;
  assign ID_EX_Bubble = idex_bubble;
  assign ctrl_state   = reset ? RUN : state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (!pc_write) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (branch_taken) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl: two instances (FLUSH=2/STALL=3 and defaults 1/1)
// checked against a cycle-indexed reference model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        memread;
  logic [4:0]  idex_rd;
  logic        branch;
  logic        imem_busy;

  logic        pcw_a, ifw_a, ifl_a, bub_a, pcw_b, ifw_b, ifl_b, bub_b;
  logic [1:0]  st_a, st_b;
  logic [31:0] sc_a, sc_b, fe_a, fe_b;

  int n_cmp = 0;
  int n_bad = 0;
  int t     = 0;
  bit primed = 1'b0;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // Model state per instance: mode 0=RUN 1=STALL 2=FLUSH 3=WAIT, end_cyc = cycle RUN resumes.
  int          mode    [2];
  int          end_cyc [2];
  int unsigned stall_n [2];
  int unsigned flush_n [2];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(3)) u_dut_a (
    .clk(clk), .reset(reset), .IF_ID__instruction(instr), .ID_EX_MemRead(memread),
    .ID_EX_rd(idex_rd), .branch_taken(branch), .imem_busy(imem_busy),
    .PC_Write(pcw_a), .IF_ID_Write(ifw_a), .IF_ID_Flush(ifl_a), .ID_EX_Bubble(bub_a),
    .ctrl_state(st_a), .stall_cycles(sc_a), .flush_events(fe_a)
  );

  pipeline_hazard_ctrl u_dut_b (
    .clk(clk), .reset(reset), .IF_ID__instruction(instr), .ID_EX_MemRead(memread),
    .ID_EX_rd(idex_rd), .branch_taken(branch), .imem_busy(imem_busy),
    .PC_Write(pcw_b), .IF_ID_Write(ifw_b), .IF_ID_Flush(ifl_b), .ID_EX_Bubble(bub_b),
    .ctrl_state(st_b), .stall_cycles(sc_b), .flush_events(fe_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, t, got, exp);
    end
  endtask

  // Expected outputs {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble} for instance k this cycle.
  task automatic model_step(input int k, output logic [3:0] exp_out, output int exp_st);
    int  fc, sc;
    bit  lu;
    fc = (k == 0) ? 2 : 1;
    sc = (k == 0) ? 3 : 1;
    lu = memread && (idex_rd != 0) &&
         (idex_rd == instr[19:15] || idex_rd == instr[24:20]);
    exp_st = reset ? 0 : mode[k];
    if (reset) begin
      exp_out    = 4'b0111;
      mode[k]    = 0;
      stall_n[k] = 0;
      flush_n[k] = 0;
    end else begin
      if (branch) begin
        exp_out = 4'b1111;
        if (fc > 1) begin mode[k] = 2; end_cyc[k] = t + fc; end
        else mode[k] = 0;
      end else if (mode[k] == 1) begin
        exp_out = 4'b0001;
        if (t + 1 >= end_cyc[k]) mode[k] = 0;
      end else if (mode[k] == 2) begin
        exp_out = {~imem_busy, 3'b110};
        if (t + 1 >= end_cyc[k]) mode[k] = imem_busy ? 3 : 0;
      end else if (lu) begin
        exp_out = 4'b0001;
        if (sc > 1) begin mode[k] = 1; end_cyc[k] = t + sc; end
        else mode[k] = 0;
      end else if (imem_busy) begin
        exp_out = 4'b0110;
        mode[k] = 3;
      end else begin
        exp_out = 4'b1100;
        mode[k] = 0;
      end
      if (!exp_out[3]) stall_n[k] = stall_n[k] + 1;
      if (branch) flush_n[k] = flush_n[k] + 1;
    end
  endtask

  task automatic cycle(input logic rst, input logic [31:0] ins, input logic mr,
                       input logic [4:0] rd, input logic br, input logic busy);
    logic [3:0]  exp_out, got_out;
    int          exp_st;
    logic [1:0]  got_st;
    logic [31:0] got_sc, got_fe;
    string       nm;
    @(negedge clk);
    reset = rst; instr = ins; memread = mr; idex_rd = rd; branch = br; imem_busy = busy;
    #1;
    $display("cycle %0d rst=%b br=%b mr=%b rd=%0d rs1=%0d rs2=%0d busy=%b | A %b%b%b%b st=%0d | B %b%b%b%b st=%0d",
             t, rst, br, mr, rd, ins[19:15], ins[24:20], busy,
             pcw_a, ifw_a, ifl_a, bub_a, st_a, pcw_b, ifw_b, ifl_b, bub_b, st_b);
    for (int k = 0; k < 2; k++) begin
      nm      = (k == 0) ? "A" : "B";
      got_out = (k == 0) ? {pcw_a, ifw_a, ifl_a, bub_a} : {pcw_b, ifw_b, ifl_b, bub_b};
      got_st  = (k == 0) ? st_a : st_b;
      got_sc  = (k == 0) ? sc_a : sc_b;
      got_fe  = (k == 0) ? fe_a : fe_b;
      if (primed) begin
        check({nm, "_stall_cycles"}, got_sc, PERF_EN ? stall_n[k] : 32'd0);
        check({nm, "_flush_events"}, got_fe, PERF_EN ? flush_n[k] : 32'd0);
      end
      model_step(k, exp_out, exp_st);
      check({nm, "_ctrl_outs"}, {28'd0, got_out}, {28'd0, exp_out});
      check({nm, "_ctrl_state"}, {30'd0, got_st}, 32'(exp_st));
      check({nm, "_noflush_hold"}, {31'd0, (!got_out[2] && got_out[1])}, 32'd0);
    end
    if (rst) primed = 1'b1;
    t++;
  endtask

  initial begin
    logic [31:0] ri;
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; end_cyc[k] = 0; stall_n[k] = 0; flush_n[k] = 0;
    end
    reset = 1'b1; instr = '0; memread = 1'b0; idex_rd = '0; branch = 1'b0; imem_busy = 1'b0;

    cycle(1, 32'h0, 0, 0, 0, 0);
    cycle(1, 32'h0, 1, 5, 1, 1);
    cycle(0, 32'h0, 0, 0, 0, 0);
    // load-use on rs1=5, then x0 exclusion
    cycle(0, 32'h0002_8000, 1, 5, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    cycle(0, 32'h0, 1, 0, 0, 0);
    // branch pulse and flush window
    cycle(0, 32'h0, 0, 0, 1, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    // branch arriving in the middle of a stall
    cycle(0, 32'h0002_8000, 1, 5, 0, 0);
    cycle(0, 32'h0002_8000, 1, 5, 1, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    // fetch wait for three cycles
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 0, 0, 0, 1);
    cycle(0, 32'h0, 0, 0, 0, 0);
    // reset in the middle of a flush
    cycle(0, 32'h0, 0, 0, 1, 0);
    cycle(1, 32'h0, 0, 0, 0, 1);
    cycle(0, 32'h0, 0, 0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      ri = $urandom;
      ri[19:15] = 5'($urandom_range(0, 3));
      ri[24:20] = 5'($urandom_range(0, 3));
      cycle($urandom_range(0, 99) < 2,
            ri,
            $urandom_range(0, 99) < 40,
            5'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
